axil_cmd_seq: RTL and testbench

- Single-outstanding AXI4-Lite master that converts a simple command interface (write or read, one word) into AXI4-Lite transactions towards a generated register block, and returns a one-cycle response with data and error status.
- Used by local controllers (init loaders, firmware bridges) to configure register banks without implementing AXI themselves.

---
 rtl/axil_cmd_seq.sv | 195 +++++++++++++++++++
 tb/tb_axil_cmd_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_seq.sv
// axil_cmd_seq: single-outstanding AXI4-Lite master turning one-word read/write commands into AXI transactions.
// Latency: accept -> rsp_valid in 3 cycles with a zero-wait slave (5 for writes when READBACK_VERIFY_EN is defined).
// Backpressure: cmd_ready only while idle, rsp_valid is a pulse with no backpressure; TIMEOUT abandons a dead slave.
module axil_cmd_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    // Counter wide enough to hold TIMEOUT; it saturates one below so it never wraps.
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    logic [2:0]            state;
    logic [2:0]            state_adv;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  arvalid_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic [CNT_W-1:0]      tmo_cnt;
`ifdef READBACK_VERIFY_EN
    logic                  we_q;
`endif

    logic accept;
    logic busy;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic tmo_fire;

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = 4'hF;
    assign bready    = (state == S_WRESP);
    assign rready    = (state == S_RRESP);

    assign accept = cmd_valid && cmd_ready;
    assign busy   = (state == S_WADDR) || (state == S_WRESP) ||
                    (state == S_RADDR) || (state == S_RRESP);
    assign aw_hs  = awvalid_q && awready;
    assign w_hs   = wvalid_q && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid_q && arready;
    assign r_hs   = rvalid && rready;

    // Normal protocol progression; a handshake that moves the FSM beats a coincident timeout.
    always_comb begin
        state_adv = state;
        unique case (state)
            S_IDLE:  if (accept) state_adv = cmd_we ? S_WADDR : S_RADDR;
            S_WADDR: if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_adv = S_WRESP;
`ifdef READBACK_VERIFY_EN
            S_WRESP: if (b_hs) state_adv = (bresp == 2'b00) ? S_RADDR : S_RSP;
`else
            S_WRESP: if (b_hs) state_adv = S_RSP;
`endif
            S_RADDR: if (ar_hs) state_adv = S_RRESP;
            S_RRESP: if (r_hs) state_adv = S_RSP;
            S_RSP:   state_adv = S_IDLE;
            default: state_adv = S_IDLE;
        endcase
    end

    assign tmo_fire  = TMO_EN && busy && (tmo_cnt >= TMO_LAST) && (state_adv == state);
    assign state_nxt = tmo_fire ? S_RSP : state_adv;

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // AXI valids: raised on accept (or readback issue), dropped on own handshake or on timeout.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else if (accept) begin
            awvalid_q <= cmd_we;
            wvalid_q  <= cmd_we;
            arvalid_q <= !cmd_we;
        end else if (tmo_fire) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (ar_hs) arvalid_q <= 1'b0;
`ifdef READBACK_VERIFY_EN
            if (b_hs && (bresp == 2'b00)) arvalid_q <= 1'b1;
`endif
        end
    end

    // Command latches and response data/status.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef READBACK_VERIFY_EN
            we_q        <= 1'b0;
`endif
        end else if (accept) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef READBACK_VERIFY_EN
            we_q        <= cmd_we;
`endif
        end else if (tmo_fire) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
        end else begin
            if (b_hs) rsp_err_q <= (bresp != 2'b00);
            if (r_hs) begin
                rsp_rdata_q <= rdata;
`ifdef READBACK_VERIFY_EN
                rsp_err_q   <= (rresp != 2'b00) || (we_q && (rdata != wdata_q));
`else
                rsp_err_q   <= (rresp != 2'b00);
`endif
            end
        end
    end

    // Cycles since accept; spans the whole transaction including any readback.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (busy && (tmo_cnt < TMO_LAST)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axil_cmd_seq.sv
// tb_axil_cmd_seq: directed bench for axil_cmd_seq with a behavioural AXI4-Lite register slave.
// Latency: slave answers B/R the cycle after the address handshake; ready delays are per-test knobs.
// Backpressure: awready/wready delays and a blocked arready exercise stalls and the timeout path.
module tb_axil_cmd_seq;

`ifdef READBACK_VERIFY_EN
    localparam bit VERIFY = 1'b1;
    localparam int WR_LAT = 5;
`else
    localparam bit VERIFY = 1'b0;
    localparam int WR_LAT = 3;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [7:0]  awaddr;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = '0;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [7:0]  araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;

    int checks = 0;
    int errors = 0;

    // slave knobs and state
    int          aw_delay = 0;
    int          w_delay = 0;
    int          aw_wait = 0;
    int          w_wait = 0;
    bit          ar_block = 1'b0;
    logic [1:0]  bresp_cfg = '0;
    logic [1:0]  rresp_cfg = '0;
    logic [31:0] corrupt = '0;
    logic [31:0] mem [256];
    bit          aw_got = 1'b0;
    bit          w_got = 1'b0;
    bit          b_pend = 1'b0;
    bit          r_pend = 1'b0;
    logic [7:0]  sl_addr = '0;
    logic [31:0] sl_data = '0;
    logic [31:0] r_val = '0;
    int          b_hs_cnt = 0;

    // per-command observations
    int aw_hi;
    int w_hi;
    int ar_hi;
    bit busy_rdy;

    axil_cmd_seq #(.ADDR_WIDTH(8), .TIMEOUT(8)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 aclk = ~aclk;

    // Slave: record handshakes seen at the rising edge (pre-update DUT values).
    always @(posedge aclk) begin
        if (areset) begin
            aw_got = 1'b0;
            w_got  = 1'b0;
            b_pend = 1'b0;
            r_pend = 1'b0;
        end else begin
            if (bvalid && bready) begin
                b_pend = 1'b0;
                b_hs_cnt++;
            end
            if (rvalid && rready) r_pend = 1'b0;
            if (awvalid && awready) begin
                aw_got  = 1'b1;
                sl_addr = awaddr;
            end
            if (wvalid && wready) begin
                w_got   = 1'b1;
                sl_data = wdata;
            end
            if (aw_got && w_got) begin
                if (bresp_cfg == 2'b00) mem[sl_addr] = sl_data;
                aw_got = 1'b0;
                w_got  = 1'b0;
                b_pend = 1'b1;
            end
            if (arvalid && arready) begin
                r_pend = 1'b1;
                r_val  = mem[araddr] ^ corrupt;
            end
        end
    end

    // Slave: drive readies and responses mid-cycle.
    always @(negedge aclk) begin
        if (awvalid) begin
            awready = (aw_wait >= aw_delay);
            aw_wait++;
        end else begin
            awready = 1'b0;
            aw_wait = 0;
        end
        if (wvalid) begin
            wready = (w_wait >= w_delay);
            w_wait++;
        end else begin
            wready = 1'b0;
            w_wait = 0;
        end
        arready = arvalid && !ar_block;
        bvalid  = b_pend;
        bresp   = b_pend ? bresp_cfg : 2'b00;
        rvalid  = r_pend;
        rdata   = r_pend ? r_val : 32'h0;
        rresp   = r_pend ? rresp_cfg : 2'b00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command at a falling edge, measure cycles to rsp_valid, check the response.
    // Returns at the falling edge one cycle after rsp_valid (next accept opportunity).
    task automatic do_cmd(input string tag, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_err, input bit hold);
        int c;
        bit seen;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(negedge aclk);
        if (!hold) cmd_valid = 1'b0;
        c = 1;
        seen = 1'b0;
        aw_hi = 0;
        w_hi = 0;
        ar_hi = 0;
        busy_rdy = 1'b0;
        while (c < 40) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (c == 1 && we) begin
                chk({tag, "_awaddr"}, 32'(awaddr), 32'(addr));
                chk({tag, "_wdata"}, wdata, wd);
                chk({tag, "_wstrb"}, 32'(wstrb), 32'hF);
            end
            aw_hi += int'(awvalid);
            w_hi  += int'(wvalid);
            ar_hi += int'(arvalid);
            busy_rdy |= cmd_ready;
            @(negedge aclk);
            c++;
        end
        chk({tag, "_latency"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_lat));
        if (seen) begin
            chk({tag, "_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
            chk({tag, "_axi_idle"}, 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        end
        @(negedge aclk);
        chk({tag, "_rsp_width"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bstart;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // reset state
        #1 areset = 1'b1;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
        chk("rst_latches", {awaddr, wdata[23:0]}, 32'd0);
        chk("rst_rsp", rsp_rdata, 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // basic write then read-back through a zero-wait slave
        do_cmd("wr0", 1'b1, 8'h00, 32'hDEADBEEF, WR_LAT, VERIFY ? 32'hDEADBEEF : 32'h0, 1'b0, 1'b0);
        chk("wr0_reg", mem[0], 32'hDEADBEEF);
        do_cmd("rd0", 1'b0, 8'h00, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0);

        // AW stalled three cycles, W immediate
        aw_delay = 3;
        bstart = b_hs_cnt;
        do_cmd("wr_awdly", 1'b1, 8'h10, 32'hA5A50001, WR_LAT + 3,
               VERIFY ? 32'hA5A50001 : 32'h0, 1'b0, 1'b0);
        chk("wr_awdly_aw_cycles", 32'(aw_hi), 32'd4);
        chk("wr_awdly_w_cycles", 32'(w_hi), 32'd1);
        chk("wr_awdly_b_count", 32'(b_hs_cnt - bstart), 32'd1);
        aw_delay = 0;

        // SLVERR write with cmd_valid held; the held command is taken only after rsp_valid
        bresp_cfg = 2'b10;
        do_cmd("wr_slverr", 1'b1, 8'h20, 32'h00000011, 3, 32'h0, 1'b1, 1'b1);
        chk("wr_slverr_noreg", mem[8'h20], 32'h0);
        bresp_cfg = 2'b00;
        do_cmd("wr_held", 1'b1, 8'h20, 32'h00000011, WR_LAT, VERIFY ? 32'h11 : 32'h0, 1'b0, 1'b0);
        chk("wr_held_reg", mem[8'h20], 32'h00000011);

        // read with SLVERR still returns the data
        rresp_cfg = 2'b10;
        do_cmd("rd_slverr", 1'b0, 8'h00, 32'h0, 3, 32'hDEADBEEF, 1'b1, 1'b0);
        rresp_cfg = 2'b00;

        // dead slave: arready never comes, timeout after 8 cycles
        ar_block = 1'b1;
        do_cmd("rd_tmo", 1'b0, 8'h30, 32'h0, 9, 32'h0, 1'b1, 1'b0);
        chk("rd_tmo_ar_cycles", 32'(ar_hi), 32'd8);
        ar_block = 1'b0;

        // reset in the middle of a stalled write
        aw_delay = 10;
        bstart = b_hs_cnt;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 8'h50;
        cmd_wdata = 32'hCAFE0001;
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(negedge aclk);
        chk("midrst_pre_aw", 32'(awvalid), 32'd1);
        areset = 1'b1;
        #1;
        chk("midrst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_latches", wdata | 32'(awaddr), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        aw_delay = 0;
        @(negedge aclk);
        chk("midrst_no_b", 32'(b_hs_cnt - bstart), 32'd0);
        chk("midrst_no_reg", mem[8'h50], 32'h0);

        // normal operation resumes after reset
        do_cmd("wr4", 1'b1, 8'h04, 32'h0BADF00D, WR_LAT, VERIFY ? 32'h0BADF00D : 32'h0, 1'b0, 1'b0);
        do_cmd("rd4", 1'b0, 8'h04, 32'h0, 3, 32'h0BADF00D, 1'b0, 1'b0);

`ifdef READBACK_VERIFY_EN
        // readback corrupted in bit 0 must be flagged
        corrupt = 32'h00000001;
        do_cmd("wr_verify", 1'b1, 8'h40, 32'h12345678, 5, 32'h12345679, 1'b1, 1'b0);
        corrupt = 32'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
